// File: rtl/reg_bus_master_if.sv
// Register bus initiator signal bundle: command/response handshakes plus the
// en/rd/wr/be/addr/data bus. The master modport is the initiator side.
interface reg_bus_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [1:0]            cmd_be;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic                  bus_en;
  logic                  bus_rd;
  logic                  bus_wr;
  logic [1:0]            bus_be;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_data_out;
  logic                  bus_data_oe;
  logic [DATA_WIDTH-1:0] bus_data_in;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata, rsp_ready, bus_data_in,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output bus_en, bus_rd, bus_wr, bus_be, bus_addr, bus_data_out, bus_data_oe
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata, rsp_ready, bus_data_in,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  bus_en, bus_rd, bus_wr, bus_be, bus_addr, bus_data_out, bus_data_oe
  );
endinterface

// File: rtl/reg_bus_master.sv
// Register bus initiator: one command at a time, registered strobes with
// programmable setup/strobe/hold, captured read data, one response per command.
//  state  | meaning
//  IDLE   | cmd_ready high, waiting for a command
//  SETUP  | en/addr/be/data driven, no strobe
//  STROBE | rd or wr high
//  HOLD   | strobe low, en/addr/be/data still held
//  RESP   | bus released, rsp_valid until rsp_ready
module reg_bus_master #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input logic            clk,
  input logic            reset,
  reg_bus_master_if.master bus
);
  localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES) ?
                           ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                           ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'((SETUP_CYCLES  > 0) ? SETUP_CYCLES  - 1 : 0);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'((STROBE_CYCLES > 0) ? STROBE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'((HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  accept, write_q, write_nxt, active_nxt;

  logic                  cmd_ready_q, en_q, rd_q, wr_q, oe_q, rsp_valid_q, rsp_write_q;
  logic                  cmd_ready_nxt, en_nxt, rd_nxt, wr_nxt, oe_nxt, rsp_valid_nxt, rsp_write_nxt;
  logic [1:0]            be_q, be_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] dout_q, dout_nxt, rdata_q, rdata_nxt;

  assign accept    = (state == IDLE) && bus.cmd_valid;
  assign write_nxt = accept ? bus.cmd_write : write_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      write_q <= write_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    case (state)
      IDLE: if (accept) begin
        if (SETUP_CYCLES > 0) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LOAD;
        end else begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LOAD;
        end
      end
      SETUP: if (cnt == '0) begin
        state_nxt = STROBE;
        cnt_nxt   = STROBE_LOAD;
      end
      STROBE: if (cnt == '0) begin
        if (HOLD_CYCLES > 0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end
      end
      HOLD: if (cnt == '0) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every bus/rsp pin is a flop.
  always_comb begin
    active_nxt    = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
    cmd_ready_nxt = (state_nxt == IDLE);
    en_nxt        = active_nxt;
    rd_nxt        = (state_nxt == STROBE) && !write_nxt;
    wr_nxt        = (state_nxt == STROBE) && write_nxt;
    oe_nxt        = active_nxt && write_nxt;
    rsp_valid_nxt = (state_nxt == RESP);
    rsp_write_nxt = (state_nxt == RESP) && write_q;
    addr_nxt      = addr_q;
    be_nxt        = be_q;
    dout_nxt      = dout_q;
    if (accept) begin
      addr_nxt = bus.cmd_addr;
      be_nxt   = bus.cmd_be;
      dout_nxt = bus.cmd_write ? bus.cmd_wdata : '0;
    end else if (!active_nxt) begin
      addr_nxt = '0;
      be_nxt   = '0;
      dout_nxt = '0;
    end
    rdata_nxt = rdata_q;
    if (accept || (state_nxt == IDLE))
      rdata_nxt = '0;
    else if ((state == STROBE) && (cnt == '0) && !write_q)
      rdata_nxt = bus.bus_data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready_q <= 1'b1;
      en_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      rdata_q     <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_nxt;
      en_q        <= en_nxt;
      rd_q        <= rd_nxt;
      wr_q        <= wr_nxt;
      oe_q        <= oe_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_write_q <= rsp_write_nxt;
      be_q        <= be_nxt;
      addr_q      <= addr_nxt;
      dout_q      <= dout_nxt;
      rdata_q     <= rdata_nxt;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.bus_en       = en_q;
  assign bus.bus_rd       = rd_q;
  assign bus.bus_wr       = wr_q;
  assign bus.bus_data_oe  = oe_q;
  assign bus.bus_be       = be_q;
  assign bus.bus_addr     = addr_q;
  assign bus.bus_data_out = dout_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_write    = rsp_write_q;
  assign bus.rsp_rdata    = rdata_q;
endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: default timing (dut_a, with a 16-entry register bank)
// and zero setup/hold timing (dut_b), checked cycle by cycle against timing arithmetic.
module tb_reg_bus_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bus_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bif_a ();
  reg_bus_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bif_b ();

  reg_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SETUP_CYCLES(1),
                   .STROBE_CYCLES(2), .HOLD_CYCLES(1))
    dut_a (.clk(clk), .reset(rst_n), .bus(bif_a.master));
  reg_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SETUP_CYCLES(0),
                   .STROBE_CYCLES(2), .HOLD_CYCLES(0))
    dut_b (.clk(clk), .reset(rst_n), .bus(bif_b.master));

  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [15:0] cmd_addr = '0, cmd_wdata = '0;
  logic [1:0]  cmd_be = '0;

  assign bif_a.cmd_valid = cmd_valid & ~sel;
  assign bif_b.cmd_valid = cmd_valid & sel;
  assign bif_a.cmd_write = cmd_write;  assign bif_b.cmd_write = cmd_write;
  assign bif_a.cmd_addr  = cmd_addr;   assign bif_b.cmd_addr  = cmd_addr;
  assign bif_a.cmd_be    = cmd_be;     assign bif_b.cmd_be    = cmd_be;
  assign bif_a.cmd_wdata = cmd_wdata;  assign bif_b.cmd_wdata = cmd_wdata;
  assign bif_a.rsp_ready = rsp_ready;  assign bif_b.rsp_ready = rsp_ready;

  // Target register bank behind dut_a; commits on the falling edge of wr.
  logic [15:0] bank [16];
  logic [15:0] exp_bank [16];
  logic [3:0]  p_addr = '0;
  logic [1:0]  p_be = '0;
  logic [15:0] p_data = '0;

  assign bif_a.bus_data_in = bif_a.bus_rd ? bank[bif_a.bus_addr[3:0]] : 16'hFFFF;
  assign bif_b.bus_data_in = bif_b.bus_rd ? 16'h1357 : 16'hFFFF;

  always @(negedge clk) if (bif_a.bus_wr) begin
    p_addr = bif_a.bus_addr[3:0];
    p_be   = bif_a.bus_be;
    p_data = bif_a.bus_data_out;
  end
  always @(negedge bif_a.bus_wr) begin
    if (p_be[0]) bank[p_addr][7:0]  = p_data[7:0];
    if (p_be[1]) bank[p_addr][15:8] = p_data[15:8];
  end

  logic        m_en, m_rd, m_wr, m_oe, m_rsp_valid, m_rsp_write, m_cmd_ready;
  logic [1:0]  m_be;
  logic [15:0] m_addr, m_dout, m_rdata;
  assign m_en        = sel ? bif_b.bus_en       : bif_a.bus_en;
  assign m_rd        = sel ? bif_b.bus_rd       : bif_a.bus_rd;
  assign m_wr        = sel ? bif_b.bus_wr       : bif_a.bus_wr;
  assign m_oe        = sel ? bif_b.bus_data_oe  : bif_a.bus_data_oe;
  assign m_be        = sel ? bif_b.bus_be       : bif_a.bus_be;
  assign m_addr      = sel ? bif_b.bus_addr     : bif_a.bus_addr;
  assign m_dout      = sel ? bif_b.bus_data_out : bif_a.bus_data_out;
  assign m_rsp_valid = sel ? bif_b.rsp_valid    : bif_a.rsp_valid;
  assign m_rsp_write = sel ? bif_b.rsp_write    : bif_a.rsp_write;
  assign m_rdata     = sel ? bif_b.rsp_rdata    : bif_a.rsp_rdata;
  assign m_cmd_ready = sel ? bif_b.cmd_ready    : bif_a.cmd_ready;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_a_strobes"}, 32'({bif_a.bus_en, bif_a.bus_rd, bif_a.bus_wr, bif_a.bus_data_oe,
                                  bif_a.bus_be, bif_a.rsp_valid, bif_a.rsp_write}), 32'h0);
    chk({tag, "_a_data"}, {bif_a.bus_addr, bif_a.bus_data_out | bif_a.rsp_rdata}, 32'h0);
    chk({tag, "_a_ready"}, 32'(bif_a.cmd_ready), 32'h1);
    chk({tag, "_b_strobes"}, 32'({bif_b.bus_en, bif_b.bus_rd, bif_b.bus_wr, bif_b.bus_data_oe,
                                  bif_b.bus_be, bif_b.rsp_valid, bif_b.rsp_write}), 32'h0);
    chk({tag, "_b_data"}, {bif_b.bus_addr, bif_b.bus_data_out | bif_b.rsp_rdata}, 32'h0);
    chk({tag, "_b_ready"}, 32'(bif_b.cmd_ready), 32'h1);
  endtask

  task automatic randomize_cmd_fields();
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = 16'($urandom);
    cmd_be    = 2'($urandom_range(0, 3));
    cmd_wdata = 16'($urandom);
  endtask

  task automatic wait_accept(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_ready", 32'(ok), 32'h1);
  endtask

  // One command with full per-cycle expectation from the configured timing.
  task automatic run_cmd(input logic w, input logic [15:0] a, input logic [1:0] be,
                         input logic [15:0] wd, input int rdelay);
    int s, t, h, lat;
    logic ok, bus_ph, strobe, rsp_ph, idle;
    logic [15:0] exp_rd;
    s = sel ? 0 : 1;
    t = 2;
    h = sel ? 0 : 1;
    lat = 1 + s + t + h;
    exp_rd = w ? 16'h0 : (sel ? 16'h1357 : exp_bank[a[3:0]]);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_be = be; cmd_wdata = wd;
    rsp_ready = 1'b0;
    wait_accept(ok);
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'($urandom_range(0, 1));
    randomize_cmd_fields();
    rsp_ready = 1'($urandom_range(0, 1));
    if (w && !sel) begin
      if (be[0]) exp_bank[a[3:0]][7:0]  = wd[7:0];
      if (be[1]) exp_bank[a[3:0]][15:8] = wd[15:8];
    end
    for (int k = 1; k <= lat + rdelay + 1; k++) begin
      @(negedge clk);
      bus_ph = (k < lat);
      strobe = bus_ph && (k > s) && (k <= s + t);
      rsp_ph = (k >= lat) && (k <= lat + rdelay);
      idle   = (k > lat + rdelay);
      chk("bus_en",      32'(m_en),        32'(bus_ph));
      chk("bus_rd",      32'(m_rd),        32'(strobe && !w));
      chk("bus_wr",      32'(m_wr),        32'(strobe && w));
      chk("bus_data_oe", 32'(m_oe),        32'(bus_ph && w));
      chk("bus_addr",    32'(m_addr),      bus_ph ? 32'(a) : 32'h0);
      chk("bus_be",      32'(m_be),        bus_ph ? 32'(be) : 32'h0);
      chk("bus_data_out",32'(m_dout),      (bus_ph && w) ? 32'(wd) : 32'h0);
      chk("rsp_valid",   32'(m_rsp_valid), 32'(rsp_ph));
      chk("rsp_write",   32'(m_rsp_write), 32'(rsp_ph && w));
      chk("cmd_ready",   32'(m_cmd_ready), 32'(idle));
      if (rsp_ph) chk("rsp_rdata", 32'(m_rdata), 32'(exp_rd));
      if (k < lat - 1) begin
        cmd_valid = 1'($urandom_range(0, 1));
        randomize_cmd_fields();
        rsp_ready = 1'($urandom_range(0, 1));
      end else begin
        cmd_valid = 1'b0;
        rsp_ready = (k == lat + rdelay);
      end
    end
    rsp_ready = 1'b0;
  endtask

  // Reset during the write strobe: everything clears at once, no response follows.
  task automatic abort_write(input logic [15:0] a, input logic [15:0] wd);
    logic ok;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_be = 2'b11; cmd_wdata = wd;
    rsp_ready = 1'b0;
    wait_accept(ok);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_wr) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_reach_strobe", 32'(ok), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", 32'({m_en, m_rd, m_wr, m_oe, m_be, m_rsp_valid}), 32'h0);
    chk("abort_addr_data", {m_addr, m_dout}, 32'h0);
    chk("abort_cmd_ready", 32'(m_cmd_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'({m_rsp_valid, m_en}), 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      bank[i] = 16'h0;
      exp_bank[i] = 16'h0;
    end
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      sel = 1'($urandom_range(0, 1));
      cmd_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      randomize_cmd_fields();
      #1;
      chk_quiet("in_reset");
    end
    @(negedge clk);
    sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_quiet("after_reset");
    end

    sel = 1'b0;
    run_cmd(1'b1, 16'h0005, 2'b11, 16'hBEEF, 0);
    chk("bank_commit_5", 32'(bank[5]), 32'h0000BEEF);
    run_cmd(1'b0, 16'h0005, 2'b11, 16'h0000, 0);
    run_cmd(1'b1, 16'h0002, 2'b11, 16'h1234, 0);
    run_cmd(1'b0, 16'h0002, 2'b11, 16'h0000, 1);
    run_cmd(1'b1, 16'h0009, 2'b11, 16'h5555, 0);
    run_cmd(1'b1, 16'h0009, 2'b01, 16'hABCD, 0);
    run_cmd(1'b0, 16'h0009, 2'b11, 16'h0000, 0);
    run_cmd(1'b1, 16'h0003, 2'b11, 16'h0F0F, 3);
    run_cmd(1'b0, 16'h0003, 2'b11, 16'h0000, 3);

    abort_write(16'h0007, 16'hDEAD);
    run_cmd(1'b1, 16'h0007, 2'b11, 16'h7777, 0);
    sel = 1'b1;
    abort_write(16'h0011, 16'hCAFE);
    run_cmd(1'b1, 16'h0011, 2'b11, 16'h2468, 0);
    run_cmd(1'b0, 16'h0011, 2'b11, 16'h0000, 2);

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int n = 0; n < 25; n++)
        run_cmd(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                16'($urandom), int'($urandom_range(0, 3)));
    end
    sel = 1'b0;
    for (int i = 0; i < 16; i++)
      run_cmd(1'b0, 16'(i), 2'b11, 16'h0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
